imem_loader: RTL

- Writer side of the instruction ROM: the CPU only reads instruction memory; this block fills it.
- Receives a program as a big-endian byte stream over a valid/ready handshake and assembles 32-bit words.
- Writes each word to consecutive instruction-memory word addresses, then checks a trailing two's-complement checksum byte.
- Holds the CPU while loading; sits beside the MIPS top, driving the instruction memory write port.

---
 rtl/imem_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a big-endian byte stream ending in a checksum byte
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Start, Word_Count     begin a load of Word_Count words (saturated to 2**ADDR_WIDTH)
//   Byte_In, Byte_Valid   stream byte and its valid; transfer needs Byte_Ready too
//   Byte_Ready            loader accepts a byte this cycle
//   Mem_Write/Addr/Data   one-cycle instruction-memory write port
//   CPU_Hold              CPU stalls while a load is in progress
//   Done, Error           load finished / checksum mismatch (Error valid when Done)
module imem_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Word_Count,
    input  logic [7:0]            Byte_In,
    input  logic                  Byte_Valid,
    output logic                  Byte_Ready,
    output logic                  Mem_Write,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [31:0]           Mem_Data,
    output logic                  CPU_Hold,
    output logic                  Done,
    output logic                  Error
);
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;

    localparam logic [ADDR_WIDTH:0]   MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   remaining, count_sat;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            byte_idx;
    logic [7:0]            sum;
    logic [31:0]           word;
    logic                  error_q, xfer, start_ok;

    assign count_sat  = (Word_Count > MAX_WORDS) ? MAX_WORDS : Word_Count;
    assign Byte_Ready = (state == RECV) || (state == CHECK);
    assign Mem_Write  = (state == WRITE);
    assign CPU_Hold   = (state == RECV) || (state == WRITE) || (state == CHECK);
    assign Done       = (state == DONE);
    assign Error      = error_q;
    assign xfer       = Byte_Valid && Byte_Ready;
    assign start_ok   = Start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = Start ? ((count_sat == '0) ? CHECK : RECV) : state;
            RECV:       state_nxt = (xfer && byte_idx == 2'd3) ? WRITE : RECV;
            WRITE:      state_nxt = (remaining == ONE_WORD) ? CHECK : RECV;
            CHECK:      state_nxt = xfer ? DONE : CHECK;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            remaining <= '0;
            addr      <= '0;
            byte_idx  <= '0;
            sum       <= '0;
            word      <= '0;
            error_q   <= 1'b0;
            Mem_Addr  <= '0;
            Mem_Data  <= '0;
        end else begin
            if (start_ok) begin
                remaining <= count_sat;
                addr      <= BASE;
                byte_idx  <= '0;
                sum       <= '0;
                error_q   <= 1'b0;
            end
            // byte_idx wraps to 0 after the 4th byte, ready for the next word
            if (state == RECV && xfer) begin
                word     <= {word[23:0], Byte_In};
                sum      <= sum + Byte_In;
                byte_idx <= byte_idx + 2'd1;
                // the write port is loaded only with complete words so partial words never show
                if (byte_idx == 2'd3) begin
                    Mem_Data <= {word[23:0], Byte_In};
                    Mem_Addr <= addr;
                end
            end
            if (state == WRITE) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == CHECK && xfer)
                error_q <= (Byte_In != 8'd0 - sum);
        end
    end
endmodule
